// File: rtl/byte_unstriping_rx.sv
// Four-lane byte un-striping receiver: each lane has its own skew FIFO, and the
// lanes are drained in strict round-robin order into one registered byte stream.
module byte_unstriping_rx #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       lane_valid,
    input  logic [WIDTH-1:0] lane0_data,
    input  logic [WIDTH-1:0] lane1_data,
    input  logic [WIDTH-1:0] lane2_data,
    input  logic [WIDTH-1:0] lane3_data,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_out,
    output logic             overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [4][DEPTH];
    logic [AW-1:0]    wr_ptr [4];
    logic [AW-1:0]    rd_ptr [4];
    logic [AW:0]      count  [4];
    logic [1:0]       rr;

    logic [WIDTH-1:0] lane_data [4];
    logic [3:0]       pop;
    logic [3:0]       push;
    logic [3:0]       drop;

    always_comb begin
        lane_data[0] = lane0_data;
        lane_data[1] = lane1_data;
        lane_data[2] = lane2_data;
        lane_data[3] = lane3_data;
        pop  = '0;
        push = '0;
        drop = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            // Only the lane under the round-robin pointer may ever be popped.
            pop[i]  = (rr == 2'(i)) && (count[i] != '0);
            push[i] = lane_valid[i] && ((count[i] != FULL) || pop[i]);
            drop[i] = lane_valid[i] && (count[i] == FULL) && !pop[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < 4; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
            rr        <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (push[i]) begin
                    mem[i][wr_ptr[i]] <= lane_data[i];
                    wr_ptr[i]         <= wr_ptr[i] + AW'(1);
                end
                if (pop[i])
                    rd_ptr[i] <= rd_ptr[i] + AW'(1);
                count[i] <= count[i] + (AW+1)'(push[i]) - (AW+1)'(pop[i]);
            end
            if (|drop)
                overflow <= 1'b1;
            valid_out <= |pop;
            if (|pop) begin
                data_out <= mem[rr][rd_ptr[rr]];
                rr       <= rr + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_byte_unstriping_rx.sv
// Directed bench for byte_unstriping_rx: expected bytes go into a scoreboard queue,
// a negedge monitor pops and compares every valid_out byte.
module tb_byte_unstriping_rx;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] lane_valid;
    logic [7:0] lane0_data, lane1_data, lane2_data, lane3_data;
    logic [7:0] data_out;
    logic       valid_out;
    logic       overflow;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q [$];

    byte_unstriping_rx #(.WIDTH(8), .DEPTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .lane_valid (lane_valid),
        .lane0_data (lane0_data),
        .lane1_data (lane1_data),
        .lane2_data (lane2_data),
        .lane3_data (lane3_data),
        .data_out   (data_out),
        .valid_out  (valid_out),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: every output byte must match the next expected byte.
    always @(negedge clk) begin
        if (valid_out === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_byte: got data_out=%02h, expected no output", data_out);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (data_out !== e) begin
                    bad++;
                    $display("FAIL stream_byte: got data_out=%02h, expected %02h", data_out, e);
                end
            end
        end
    end

    task automatic cyc(input logic [3:0] v, input logic [7:0] d0, input logic [7:0] d1,
                       input logic [7:0] d2, input logic [7:0] d3);
        lane_valid = v;
        lane0_data = d0;
        lane1_data = d1;
        lane2_data = d2;
        lane3_data = d3;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(4'h0, 8'h00, 8'h00, 8'h00, 8'h00);
    endtask

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %02h, expected %02h", name, got, want);
        end
    endtask

    task automatic chk_v(input string name, input logic want);
        chk(name, {7'd0, valid_out}, {7'd0, want});
    endtask

    task automatic chk_rst_state(input string name);
        chk({name, "_data"}, data_out, 8'h00);
        chk_v({name, "_valid"}, 1'b0);
        chk({name, "_ovf"}, {7'd0, overflow}, 8'h00);
    endtask

    initial begin
        // Reset held two cycles while all lanes present random bytes.
        reset = 1'b1;
        for (int unsigned k = 0; k < 2; k++) begin
            cyc(4'hF, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
            chk_rst_state("reset_hold");
        end
        reset = 1'b0;
        idle();
        chk_rst_state("reset_release");

        // In-order, one lane per cycle.
        exp_q.push_back(8'h11); exp_q.push_back(8'h22);
        exp_q.push_back(8'h33); exp_q.push_back(8'h44);
        cyc(4'h1, 8'h11, 8'h00, 8'h00, 8'h00); chk_v("inorder_lat0", 1'b0);
        cyc(4'h2, 8'h00, 8'h22, 8'h00, 8'h00); chk_v("inorder_v1", 1'b1);
        cyc(4'h4, 8'h00, 8'h00, 8'h33, 8'h00); chk_v("inorder_v2", 1'b1);
        cyc(4'h8, 8'h00, 8'h00, 8'h00, 8'h44); chk_v("inorder_v3", 1'b1);
        idle(); chk_v("inorder_v4", 1'b1);
        idle(); chk_v("inorder_end", 1'b0);
        chk("inorder_hold", data_out, 8'h44);

        // Skew: lanes 2 and 3 lead lane 0 by three cycles.
        exp_q.push_back(8'h11); exp_q.push_back(8'h22);
        exp_q.push_back(8'h33); exp_q.push_back(8'h44);
        cyc(4'hC, 8'h00, 8'h00, 8'h33, 8'h44); chk_v("skew_wait0", 1'b0);
        idle(); chk_v("skew_wait1", 1'b0);
        idle(); chk_v("skew_wait2", 1'b0);
        cyc(4'h3, 8'h11, 8'h22, 8'h00, 8'h00); chk_v("skew_wait3", 1'b0);
        for (int unsigned k = 0; k < 4; k++) begin
            idle(); chk_v("skew_burst", 1'b1);
        end
        idle(); chk_v("skew_end", 1'b0);

        // Full width: all four lanes for two cycles.
        for (int unsigned k = 0; k < 4; k++) exp_q.push_back(8'hA0 + 8'(k));
        for (int unsigned k = 0; k < 4; k++) exp_q.push_back(8'hB0 + 8'(k));
        cyc(4'hF, 8'hA0, 8'hA1, 8'hA2, 8'hA3); chk_v("full_lat0", 1'b0);
        cyc(4'hF, 8'hB0, 8'hB1, 8'hB2, 8'hB3); chk_v("full_burst", 1'b1);
        for (int unsigned k = 0; k < 7; k++) begin
            idle(); chk_v("full_burst", 1'b1);
        end
        idle(); chk_v("full_end", 1'b0);
        chk("full_ovf", {7'd0, overflow}, 8'h00);

        // Overflow: lane1 overfilled while lane0 idle; fifth byte is dropped.
        for (int unsigned k = 1; k <= 5; k++) begin
            cyc(4'h2, 8'h00, 8'(k), 8'h00, 8'h00);
            chk_v("ovf_stall", 1'b0);
            if (k == 4) chk("ovf_before", {7'd0, overflow}, 8'h00);
        end
        chk("ovf_set", {7'd0, overflow}, 8'h01);
        exp_q.push_back(8'hAA); exp_q.push_back(8'h01);
        cyc(4'h1, 8'hAA, 8'h00, 8'h00, 8'h00); chk_v("ovf_lat0", 1'b0);
        idle(); chk_v("ovf_out_aa", 1'b1);
        idle(); chk_v("ovf_out_01", 1'b1);
        idle(); chk_v("ovf_rr_stall", 1'b0);
        chk("ovf_sticky", {7'd0, overflow}, 8'h01);

        // Reset clears leftover lane1 bytes and the sticky flag.
        reset = 1'b1;
        cyc(4'hF, 8'h99, 8'h99, 8'h99, 8'h99);
        reset = 1'b0;
        chk_rst_state("reset_clear");

        // Reset mid-operation with three bytes buffered in lane1 and rr=1.
        for (int unsigned k = 1; k <= 3; k++) begin
            cyc(4'h2, 8'h00, 8'(k), 8'h00, 8'h00);
            chk_v("mid_fill", 1'b0);
        end
        exp_q.push_back(8'h77);
        cyc(4'h1, 8'h77, 8'h00, 8'h00, 8'h00); chk_v("mid_lat0", 1'b0);
        idle(); chk_v("mid_out_77", 1'b1);
        reset = 1'b1;
        idle();
        reset = 1'b0;
        chk_v("mid_reset", 1'b0);
        exp_q.push_back(8'h5A);
        cyc(4'h1, 8'h5A, 8'h00, 8'h00, 8'h00); chk_v("mid_lat_5a", 1'b0);
        idle(); chk_v("mid_out_5a", 1'b1);
        for (int unsigned k = 0; k < 3; k++) begin
            idle(); chk_v("mid_discarded", 1'b0);
        end

        chk("scoreboard_drained", 8'(exp_q.size()), 8'h00);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
